// File: rtl/lane_register_scheduler.sv
// Sequencer for the 4-lane note register: fetches a pattern row per beat, runs a
// fixed hit window in which key presses clear lanes, then scores hits and misses.
module lane_register_scheduler #(
  parameter int WIN_CYC = 16,
  parameter int CNT_W   = 8
) (
  input  logic             C,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             beat,
  output logic             row_req,
  input  logic             row_vld,
  input  logic [3:0]       row_data,
  input  logic             row_last,
  input  logic [3:0]       key,
  output logic [3:0]       reg_d,
  output logic [3:0]       reg_clr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WIN   = 3'd2,
    S_SCORE = 3'd3,
    S_WAIT  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [7:0]       WIN_LD  = 8'(WIN_CYC - 1);

  state_e           state_q, state_d;
  logic [3:0]       lanes_q, lanes_d;
  logic             last_q, last_d;
  logic [7:0]       win_q, win_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic             done_q, done_d;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    pop4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Add at full width, then clamp so the score never wraps.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W+2:0] s;
    s = (CNT_W+3)'(a) + (CNT_W+3)'(b);
    if (s > (CNT_W+3)'(CNT_MAX)) begin
      sat_add = CNT_MAX;
    end else begin
      sat_add = s[CNT_W-1:0];
    end
  endfunction

  // Next-state, lane mirror and score update.
  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    last_d  = last_q;
    win_d   = win_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      lanes_d = 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          lanes_d = 4'b0000;
          if (start) begin
            state_d = S_REQ;
            hit_d   = '0;
            miss_d  = '0;
            last_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_REQ: begin
          if (row_vld) begin
            lanes_d = row_data;
            last_d  = row_last;
            win_d   = WIN_LD;
            state_d = S_WIN;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WIN: begin
          lanes_d = lanes_q & ~key;
          hit_d   = sat_add(hit_q, pop4(key & lanes_q));
          miss_d  = sat_add(miss_q, pop4(key & ~lanes_q));
          if (win_q == 8'd0) begin
            state_d = S_SCORE;
          end else begin
            win_d = win_q - 8'd1;
          end
        end
        S_SCORE: begin
          miss_d  = sat_add(miss_q, pop4(lanes_q));
          lanes_d = 4'b0000;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (beat) begin
            state_d = S_REQ;
          end else begin
            state_d = S_WAIT;
          end
        end
        default: begin
          state_d = S_IDLE;
          lanes_d = 4'b0000;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge C) begin
    if (clr) begin
      state_q <= S_IDLE;
      lanes_q <= 4'b0000;
      last_q  <= 1'b0;
      win_q   <= 8'd0;
      hit_q   <= '0;
      miss_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      last_q  <= last_d;
      win_q   <= win_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      done_q  <= done_d;
    end
  end

  // reg_d leads lanes_q by one edge so the external register Q tracks lanes_q.
  assign reg_d    = clr ? 4'b0000 : lanes_d;
  assign reg_clr  = {4{clr}};
  assign row_req  = (state_q == S_REQ);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;

endmodule

// File: doc/lane_register_scheduler.md
# lane_register_scheduler

Sequencing controller for the 4-lane note register (one `Dflipflopinit` bit per finger lane). It fetches note rows from the pattern source on each beat, loads them into the register, opens a fixed-length hit window in which key presses clear individual lanes, then scores hits and misses. It sits between the pattern ROM/beat generator, the key debouncers, and the `register4bit_async` instance, and is the only driver of that register's D and clr inputs.

## Interface
- `WIN_CYC`, default 16: hit-window length in clock cycles; legal range 2..255.
- `CNT_W`, default 8: width of the hit and miss counters.

- `C`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  synchronous active-high reset.
- `start`  in  1  one-cycle pulse that begins a song; honoured only in IDLE.
- `stop`  in  1  abort; priority over everything except `clr`.
- `beat`  in  1  one-cycle beat tick; honoured only in WAIT.
- `row_req`  out  1  request for the next pattern row.
- `row_vld`  in  1  row_data/row_last valid.
- `row_data`  in  4  lane pattern; bit i = note on lane i.
- `row_last`  in  1  the accepted row is the final row of the song.
- `key`  in  4  one-cycle key-press pulses, one per lane.
- `reg_d`  out  4  D input of the lane register.
- `reg_clr`  out  4  clr inputs of the lane register.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when a song completes normally.
- `hit_cnt`  out  CNT_W  saturating count of correct presses.
- `miss_cnt`  out  CNT_W  saturating count of wrong presses plus unhit notes.

## Operation
- Internal `lanes[3:0]` mirrors the register. `reg_d` is the combinational next value of `lanes`, so the register Q equals `lanes` every cycle.
- `reg_clr` = {4{clr}}. The register's set inputs are tied low at the top level.
- States: IDLE, REQ, WIN, SCORE, WAIT.
- IDLE: `lanes`=0. On `start`, go to REQ.
- REQ: `row_req`=1. In the cycle where `row_req && row_vld`:
  - `lanes` <= row_data;
  - latch row_last into `last_f`;
  - load window counter with WIN_CYC-1;
  - go to WIN.
- WIN: for each i with key[i]=1:
  - lane set: clear lane i and add 1 to hit_cnt;
  - lane clear: add 1 to miss_cnt.
  - Multiple keys in one cycle add their popcount in that same cycle. The counter decrements each cycle; when it reaches 0, go to SCORE.
- SCORE (1 cycle):
  - miss_cnt += popcount(lanes);
  - `lanes` <= 0;
  - if `last_f`, pulse `done` and go to IDLE; else go to WAIT.
- WAIT: on `beat`, go to REQ. `key` is ignored in WAIT.
- `key` is ignored outside WIN, including in the cycle a row is accepted.
- `start` is ignored when not in IDLE. `beat` is ignored outside WAIT.
- Counter arithmetic: add at full width, then saturate at 2^CNT_W-1; the counters never wrap.
- Counters clear on `start` accepted in IDLE, and on `clr`. They hold their value across IDLE so the score remains readable.
- `stop` (any state): `lanes` <= 0, go to IDLE, no `done`, counters hold.
- `clr`: all state goes to reset values regardless of other inputs.

## Timing
- Reset values: state IDLE, lanes 0, reg_d 0, row_req 0, busy 0, done 0, hit_cnt 0, miss_cnt 0, last_f 0.
- `start` at edge n: REQ from cycle n+1, with row_req high in that same cycle.
- `row_req` stays high until the accepting edge and is low the cycle after. A row presented without `row_req` is not consumed.
- Row accepted at edge m: register Q = row_data from cycle m+1. WIN covers exactly WIN_CYC cycles (m+1..m+WIN_CYC). SCORE is in cycle m+WIN_CYC+1.
- A key on the last WIN cycle counts, and its lane clear is visible to SCORE.
- `done` is high for exactly the SCORE→IDLE transition cycle +1, i.e., the first IDLE cycle.
- Beat to next row request latency: 1 cycle.

## Test plan
- Reset then idle:
  - clr high 3 cycles with row_vld=1 and key=4'hF → all outputs 0, reg_clr=4'hF during clr, row_req never high.
- Single-row perfect song:
  - start; row 4'b1010 with row_last=1 accepted; key=4'b0010 in WIN cycle 2, key=4'b1000 in cycle 5 → hit_cnt=2, miss_cnt=0, done pulses one cycle after SCORE, Q returns to 0.
- Wrong and missed notes:
  - row 4'b0110; key=4'b0011 in WIN cycle 1 → hit 1 (lane 1), miss 1 (lane 0);
  - SCORE adds 1 for lane 2 → hit_cnt=1, miss_cnt=2.
- Multi-row with beats:
  - rows 4'b0001, 4'b1111 (last); beat arrives 5 cycles after first SCORE; no keys → REQ exactly one cycle after beat, miss_cnt=5, single done.
- Boundary and priority:
  - key=4'b0001 on final WIN cycle → hit counted, no miss for lane 0;
  - row_vld held low 10 cycles → row_req stays high and the state stays REQ;
  - stop mid-WIN → Q=0 next cycle, IDLE, no done;
  - start while busy is ignored.
- Saturation:
  - CNT_W=2, WIN_CYC=2; 3 rows of 4'b1111 with no keys → miss_cnt saturates at 3 and does not wrap.
